ppu_vram_arbiter: RTL and testbench



---
 rtl/ppu_pkg.sv | 28 ++
 rtl/ppu_arb_pick.sv | 23 ++
 rtl/ppu_vram_arbiter.sv | 134 +++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM arbiter: FSM states, one-hot
// requester ids, and the 14-bit address fold applied to every latched address.
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    SRC_BG  = 3'b001,
    SRC_SPR = 3'b010,
    SRC_CPU = 3'b100
  } arb_src_t;

  localparam logic [15:0] PPU_ADDR_MASK = 16'h3FFF;
  localparam int          NT_MIRROR_BIT = 12;

  // Nametable mirror 0x3000-0x3EFF onto 0x2000-0x2EFF; palette 0x3Fxx is left alone.
  function automatic logic [15:0] ppu_fold_addr(input logic [15:0] addr);
    logic [15:0] m;
    m = addr & PPU_ADDR_MASK;
    if (m[13:12] == 2'b11 && m[11:8] != 4'hF) m[NT_MIRROR_BIT] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ppu_arb_pick.sv
// Combinational fixed-priority picker (bg > spr > cpu) with a CPU override input.
module ppu_arb_pick
  import ppu_pkg::*;
(
  input  logic     bg_req,
  input  logic     spr_req,
  input  logic     cpu_req,
  input  logic     force_cpu,
  output logic     valid,
  output arb_src_t src
);

  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    valid = bg_req | spr_req | cpu_req;
    src   = SRC_BG;
    if (force_cpu && cpu_req) src = SRC_CPU;
    else if (bg_req)          src = SRC_BG;
    else if (spr_req)         src = SRC_SPR;
    else if (cpu_req)         src = SRC_CPU;
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Three-way VRAM port arbiter with two-cycle ISSUE/RESP transactions.
// Define PPU_ARB_CPU_AGE_EN to add the CPU anti-starvation age counter.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int AGE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bg_req,
  input  logic        spr_req,
  input  logic        cpu_req,
  input  logic [15:0] bg_addr,
  input  logic [15:0] spr_addr,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        bg_gnt,
  output logic        spr_gnt,
  output logic        cpu_gnt,
  output logic        bg_ack,
  output logic        spr_ack,
  output logic        cpu_ack,
  output logic [7:0]  rdata,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata
);

  if (AGE_MAX < 1 || AGE_MAX > 15) begin : g_bad_age_max
    $error("AGE_MAX must fit the 4-bit age counter (1..15)");
  end

  arb_state_t  state_q, state_d;
  arb_src_t    src_q, src_d;
  logic [15:0] vram_addr_q, vram_addr_d;
  logic        vram_we_q, vram_we_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;

  logic        decide;
  logic        pick_valid;
  arb_src_t    pick_src;
  logic        force_cpu;

  assign decide = (state_q == IDLE) || (state_q == RESP);

  ppu_arb_pick u_pick (
    .bg_req    (bg_req),
    .spr_req   (spr_req),
    .cpu_req   (cpu_req),
    .force_cpu (force_cpu),
    .valid     (pick_valid),
    .src       (pick_src)
  );

`ifdef PPU_ARB_CPU_AGE_EN
  localparam logic [3:0] AGE_LIMIT = 4'(AGE_MAX);

  logic [3:0] age_q, age_d;

  assign force_cpu = (age_q >= AGE_LIMIT);

  always_comb begin
    age_d = age_q;
    if (decide) begin
      if (!cpu_req || pick_src == SRC_CPU) age_d = 4'd0;
      else if (age_q != 4'hF)              age_d = age_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) age_q <= 4'd0;
    else       age_q <= age_d;
  end
`else
  assign force_cpu = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    vram_addr_d  = vram_addr_q;
    vram_we_d    = 1'b0;
    vram_wdata_d = vram_wdata_q;
    if (state_q == ISSUE) begin
      state_d = RESP;
    end else if (pick_valid) begin
      state_d = ISSUE;
      src_d   = pick_src;
      unique case (pick_src)
        SRC_BG:  vram_addr_d = ppu_fold_addr(bg_addr);
        SRC_SPR: vram_addr_d = ppu_fold_addr(spr_addr);
        default: vram_addr_d = ppu_fold_addr(cpu_addr);
      endcase
      if (pick_src == SRC_CPU && cpu_we) begin
        vram_we_d    = 1'b1;
        vram_wdata_d = cpu_wdata;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  // The async reset clears vram_we_q immediately, cutting off a write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= SRC_BG;
      vram_addr_q  <= 16'h0000;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
    end
  end

  assign bg_gnt     = (state_q == ISSUE) && (src_q == SRC_BG);
  assign spr_gnt    = (state_q == ISSUE) && (src_q == SRC_SPR);
  assign cpu_gnt    = (state_q == ISSUE) && (src_q == SRC_CPU);
  assign bg_ack     = (state_q == RESP)  && (src_q == SRC_BG);
  assign spr_ack    = (state_q == RESP)  && (src_q == SRC_SPR);
  assign cpu_ack    = (state_q == RESP)  && (src_q == SRC_CPU);
  assign rdata      = vram_rdata;
  assign vram_addr  = vram_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed self-checking bench for ppu_vram_arbiter with a 1-cycle-latency VRAM model.
// Covers both builds of PPU_ARB_CPU_AGE_EN.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bg_req = 1'b0, spr_req = 1'b0, cpu_req = 1'b0;
  logic [15:0] bg_addr = '0, spr_addr = '0, cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic        bg_gnt, spr_gnt, cpu_gnt, bg_ack, spr_ack, cpu_ack;
  logic [7:0]  rdata;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem [0:16383];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ppu_vram_arbiter #(.AGE_MAX(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bg_req     (bg_req),
    .spr_req    (spr_req),
    .cpu_req    (cpu_req),
    .bg_addr    (bg_addr),
    .spr_addr   (spr_addr),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .bg_gnt     (bg_gnt),
    .spr_gnt    (spr_gnt),
    .cpu_gnt    (cpu_gnt),
    .bg_ack     (bg_ack),
    .spr_ack    (spr_ack),
    .cpu_ack    (cpu_ack),
    .rdata      (rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  // Synchronous VRAM: write on the edge ending ISSUE, read data registered for RESP.
  always @(posedge clk) begin
    if (pl_en)        mem[pl_addr] <= pl_data;
    else if (vram_we) mem[vram_addr[13:0]] <= vram_wdata;
    vram_rdata <= mem[vram_addr[13:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  function automatic logic [5:0] obs();
    return {bg_gnt, spr_gnt, cpu_gnt, bg_ack, spr_ack, cpu_ack};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    preload(14'h2041, 8'h5A);
    preload(14'h2005, 8'h99);
    total++; if (obs() !== 6'b0) begin bad++; $display("FAIL reset_handshake got=%b exp=000000", obs()); end
    total++; if (vram_addr !== 16'h0) begin bad++; $display("FAIL reset_vram_addr got=%h exp=0000", vram_addr); end
    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL reset_vram_we got=%b exp=0", vram_we); end
    total++; if (vram_wdata !== 8'h0) begin bad++; $display("FAIL reset_vram_wdata got=%h exp=00", vram_wdata); end
    reset = 1'b0;
    tick();
    total++; if (obs() !== 6'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=000000", obs()); end
  endtask

  task automatic test_single_bg();
    bg_req = 1'b1; bg_addr = 16'h2041;
    tick();
    total++; if (obs() !== 6'b100000) begin bad++; $display("FAIL bg_gnt_plus1 got=%b exp=100000", obs()); end
    total++; if (vram_addr !== 16'h2041) begin bad++; $display("FAIL bg_vram_addr got=%h exp=2041", vram_addr); end
    bg_req = 1'b0;
    tick();
    total++; if (obs() !== 6'b000100) begin bad++; $display("FAIL bg_ack_plus2 got=%b exp=000100", obs()); end
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL bg_rdata got=%h exp=5a", rdata); end
    tick();
    total++; if (obs() !== 6'b0) begin bad++; $display("FAIL bg_back_idle got=%b exp=000000", obs()); end
  endtask

  task automatic test_priority();
    logic [5:0] exp_tab [9];
    exp_tab = '{6'b100000, 6'b000100, 6'b100000, 6'b000100,
                6'b010000, 6'b000010, 6'b001000, 6'b000001, 6'b000000};
    bg_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    bg_addr = 16'h0100; spr_addr = 16'h0200; cpu_addr = 16'h0300;
    for (int c = 0; c < 9; c++) begin
      tick();
      total++;
      if (obs() !== exp_tab[c]) begin
        bad++; $display("FAIL priority_cycle%0d got=%b exp=%b", c + 1, obs(), exp_tab[c]);
      end
      if (c == 2) bg_req = 1'b0;
      if (c == 4) spr_req = 1'b0;
      if (c == 6) cpu_req = 1'b0;
    end
  endtask

  task automatic test_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3F10; cpu_wdata = 8'h21;
    tick();
    total++; if (obs() !== 6'b001000) begin bad++; $display("FAIL wr_gnt got=%b exp=001000", obs()); end
    total++; if (vram_we !== 1'b1) begin bad++; $display("FAIL wr_we_issue got=%b exp=1", vram_we); end
    total++; if (vram_addr !== 16'h3F10) begin bad++; $display("FAIL wr_addr got=%h exp=3f10", vram_addr); end
    total++; if (vram_wdata !== 8'h21) begin bad++; $display("FAIL wr_wdata got=%h exp=21", vram_wdata); end
    cpu_we = 1'b0; cpu_wdata = 8'hEE;
    tick();
    total++; if (obs() !== 6'b000001) begin bad++; $display("FAIL wr_ack got=%b exp=000001", obs()); end
    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL wr_we_resp got=%b exp=0", vram_we); end
    tick();
    total++; if (obs() !== 6'b001000) begin bad++; $display("FAIL rd_gnt got=%b exp=001000", obs()); end
    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", vram_we); end
    total++; if (vram_wdata !== 8'h21) begin bad++; $display("FAIL wdata_hold got=%h exp=21", vram_wdata); end
    cpu_req = 1'b0;
    tick();
    total++; if (obs() !== 6'b000001) begin bad++; $display("FAIL rd_ack got=%b exp=000001", obs()); end
    total++; if (rdata !== 8'h21) begin bad++; $display("FAIL rd_after_wr got=%h exp=21", rdata); end
    tick();
  endtask

  task automatic test_fold();
    logic [15:0] in_tab  [3];
    logic [15:0] exp_tab [3];
    in_tab  = '{16'h3123, 16'hC005, 16'h3EFF};
    exp_tab = '{16'h2123, 16'h0005, 16'h2EFF};
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = in_tab[i];
      tick();
      total++;
      if (vram_addr !== exp_tab[i]) begin
        bad++; $display("FAIL fold_%h got=%h exp=%h", in_tab[i], vram_addr, exp_tab[i]);
      end
      cpu_req = 1'b0;
      tick();
    end
    tick();
  endtask

  task automatic test_starvation();
    bg_req = 1'b1; bg_addr = 16'h0000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
`ifdef PPU_ARB_CPU_AGE_EN
    for (int d = 1; d <= 9; d++) begin
      tick();
      total++;
      if (obs() !== ((d < 9) ? 6'b100000 : 6'b001000)) begin
        bad++; $display("FAIL age_decision%0d got=%b exp=%b", d, obs(), (d < 9) ? 6'b100000 : 6'b001000);
      end
      if (d == 8) begin
        total++; if (dut.age_q !== 4'd8) begin bad++; $display("FAIL age_count8 got=%0d exp=8", dut.age_q); end
      end
      if (d == 9) begin
        total++; if (dut.age_q !== 4'd0) begin bad++; $display("FAIL age_cleared got=%0d exp=0", dut.age_q); end
        cpu_req = 1'b0;
      end
      tick();
    end
`else
    begin
      int bg_cnt = 0;
      int cpu_cnt = 0;
      for (int d = 1; d <= 100; d++) begin
        tick();
        if (bg_gnt) bg_cnt++;
        if (cpu_gnt) cpu_cnt++;
        tick();
      end
      total++; if (cpu_cnt !== 0) begin bad++; $display("FAIL starve_cpu_gnts got=%0d exp=0", cpu_cnt); end
      total++; if (bg_cnt !== 100) begin bad++; $display("FAIL starve_bg_gnts got=%0d exp=100", bg_cnt); end
    end
    cpu_req = 1'b0;
`endif
    bg_req = 1'b0;
    tick();
    tick();
    total++; if (obs() !== 6'b0) begin bad++; $display("FAIL starve_idle got=%b exp=000000", obs()); end
  endtask

  task automatic test_reset_mid_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2005; cpu_wdata = 8'h77;
    tick();
    total++; if (vram_we !== 1'b1) begin bad++; $display("FAIL rst_pre_we got=%b exp=1", vram_we); end
    #2 reset = 1'b1;
    #1;
    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL rst_we_async got=%b exp=0", vram_we); end
    total++; if (obs() !== 6'b0) begin bad++; $display("FAIL rst_handshake got=%b exp=000000", obs()); end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b0;
    total++; if (vram_addr !== 16'h0) begin bad++; $display("FAIL rst_vram_addr got=%h exp=0000", vram_addr); end
    total++; if (vram_wdata !== 8'h0) begin bad++; $display("FAIL rst_vram_wdata got=%h exp=00", vram_wdata); end
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (obs() !== 6'b0) begin bad++; $display("FAIL rst_no_ack%0d got=%b exp=000000", c, obs()); end
    end
    total++; if (mem[14'h2005] !== 8'h99) begin bad++; $display("FAIL rst_no_write got=%h exp=99", mem[14'h2005]); end
  endtask

  initial begin
    test_reset();
    test_single_bg();
    test_priority();
    test_write_read();
    test_fold();
    test_starvation();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
